// File: rtl/conv_pkg.sv
// conv_pkg: shared constants, datapath types and FSM states for the 5x5 convolution stage.
// IMG_W/OUT_W : padded input row width and output row width.
// K           : kernel side length.
// NPIX/NOUT   : pixels read and outputs produced per frame.
package conv_pkg;

    localparam int unsigned IMG_W = 32;
    localparam int unsigned OUT_W = 28;
    localparam int unsigned K     = 5;
    localparam int unsigned NPIX  = 1024;
    localparam int unsigned NOUT  = 784;

    typedef logic        [7:0]  pix_t;
    typedef logic signed [7:0]  wt_t;
    typedef logic signed [16:0] prod_t;
    typedef logic signed [21:0] acc_t;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

endpackage

// File: rtl/conv5x5_engine_if.sv
// conv5x5_engine_if: control, weight-load, input-SRAM read and output-write signals of the
// convolution engine.
// master : the surrounding system (drives start/weights/read data, observes everything else).
// slave  : the engine itself.
interface conv5x5_engine_if;
    import conv_pkg::*;

    logic       start;
    logic       wt_wr;
    logic [4:0] wt_idx;
    wt_t        wt_data;
    logic       sram_re;
    logic [9:0] sram_raddr;
    pix_t       sram_rdata;
    pix_t       conv_out;
    logic [9:0] out_addr;
    logic       out_vld;
    logic       busy;
    logic       done;

    modport master (
        output start, wt_wr, wt_idx, wt_data, sram_rdata,
        input  sram_re, sram_raddr, conv_out, out_addr, out_vld, busy, done
    );

    modport slave (
        input  start, wt_wr, wt_idx, wt_data, sram_rdata,
        output sram_re, sram_raddr, conv_out, out_addr, out_vld, busy, done
    );

endinterface

// File: rtl/conv_window_gen.sv
// conv_window_gen: turns the row-major pixel stream into a sliding 5x5 window.
// clk, rst_n : clock, asynchronous active-low reset.
// clear_i    : frame start, restarts row/col tracking.
// pix_vld_i  : pix_i holds the next pixel of the frame.
// win_o      : win_o[i][j] = P[r-4+i][c-4+j] for the pixel (r,c) captured last.
// win_vld_o  : window is fully inside one frame region (r>=4, c>=4).
// row_o/col_o: position of the pixel captured last.
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int unsigned LineW = IMG_W,
    localparam int unsigned CW   = $clog2(LineW)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear_i,
    input  logic                    pix_vld_i,
    input  pix_t                    pix_i,
    output pix_t [K-1:0][K-1:0]     win_o,
    output logic                    win_vld_o,
    output logic [CW-1:0]           row_o,
    output logic [CW-1:0]           col_o
);

    // lb_q[k][c] holds P[r-1-k][c] relative to the incoming pixel's row r.
    pix_t                lb_q [K-1][LineW];
    pix_t [K-1:0][K-1:0] win_q;
    pix_t [K-1:0]        new_col;
    logic [CW-1:0]       cnt_r_q, cnt_c_q;
    logic [CW-1:0]       row_q, col_q;
    logic                win_vld_q;

    // Column entering the window: oldest row at index 0, incoming pixel at the bottom.
    always_comb begin
        new_col        = '0;
        new_col[K-1]   = pix_i;
        for (int k = 0; k < K - 1; k++) begin
            new_col[K-2-k] = lb_q[k][cnt_c_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < K - 1; k++) begin
                for (int c = 0; c < LineW; c++) begin
                    lb_q[k][c] <= '0;
                end
            end
            win_q     <= '0;
            cnt_r_q   <= '0;
            cnt_c_q   <= '0;
            row_q     <= '0;
            col_q     <= '0;
            win_vld_q <= 1'b0;
        end else begin
            win_vld_q <= 1'b0;
            if (clear_i) begin
                cnt_r_q <= '0;
                cnt_c_q <= '0;
            end else if (pix_vld_i) begin
                lb_q[0][cnt_c_q] <= pix_i;
                for (int k = 1; k < K - 1; k++) begin
                    lb_q[k][cnt_c_q] <= lb_q[k-1][cnt_c_q];
                end
                for (int i = 0; i < K; i++) begin
                    for (int j = 0; j < K - 1; j++) begin
                        win_q[i][j] <= win_q[i][j+1];
                    end
                    win_q[i][K-1] <= new_col[i];
                end
                row_q <= cnt_r_q;
                col_q <= cnt_c_q;
                // c<4 windows straddle two rows; r<4 windows still hold stale line data.
                win_vld_q <= (cnt_r_q >= CW'(K - 1)) && (cnt_c_q >= CW'(K - 1));
                if (cnt_c_q == CW'(LineW - 1)) begin
                    cnt_c_q <= '0;
                    cnt_r_q <= cnt_r_q + CW'(1);
                end else begin
                    cnt_c_q <= cnt_c_q + CW'(1);
                end
            end
        end
    end

    assign win_o     = win_q;
    assign win_vld_o = win_vld_q;
    assign row_o     = row_q;
    assign col_o     = col_q;

endmodule

// File: rtl/conv5x5_engine.sv
// conv5x5_engine: reads a zero-padded IMG_W x IMG_W image from SRAM, applies a programmable
// signed 5x5 kernel (stride 1), then ReLU, >>> SHIFT and saturation to 8 bits.
// clk, rst_n : clock, asynchronous active-low reset.
// bus_io     : start/weight load, input SRAM read port, output pixel stream, busy/done.
// Pipeline: read issue t, window capture t+1, products t+2, sum/ReLU/sat t+3, visible t+4.
module conv5x5_engine #(
    parameter int unsigned SHIFT = 4,
    parameter int unsigned IMG_W = conv_pkg::IMG_W,
    parameter int unsigned OUT_W = conv_pkg::OUT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    conv5x5_engine_if.slave       bus_io
);
    import conv_pkg::*;

    localparam int unsigned NTAP     = K * K;
    localparam int unsigned CW       = $clog2(IMG_W);
    localparam logic [9:0]  LastAddr = 10'(IMG_W * IMG_W - 1);

    state_t               state_q, state_d;
    logic [9:0]           raddr_q, raddr_d;
    logic [1:0]           drain_q, drain_d;
    logic                 frame_start;
    logic                 rd_vld_q;
    wt_t                  wt_q [NTAP];

    pix_t [K-1:0][K-1:0]  win;
    logic                 win_vld;
    logic [CW-1:0]        win_row, win_col;

    prod_t                prod_q [NTAP];
    logic                 prod_vld_q;
    acc_t                 sum, sum_sh;
    pix_t                 pix_res;

    pix_t                 conv_out_q;
    logic [9:0]           out_addr_q, out_cnt_q;
    logic                 out_vld_q;

    assign frame_start = (state_q == IDLE) && bus_io.start;

    always_comb begin
        state_d = state_q;
        raddr_d = raddr_q;
        drain_d = drain_q;
        unique case (state_q)
            IDLE: begin
                if (bus_io.start) begin
                    state_d = READ;
                    raddr_d = '0;
                end
            end
            READ: begin
                if (raddr_q == LastAddr) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end else begin
                    raddr_d = raddr_q + 10'd1;
                end
            end
            DRAIN: begin
                drain_d = drain_q + 2'd1;
                if (drain_q == 2'd3) state_d = DONE;
            end
            DONE: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            raddr_q  <= '0;
            drain_q  <= '0;
            rd_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            raddr_q  <= raddr_d;
            drain_q  <= drain_d;
            rd_vld_q <= (state_q == READ);
        end
    end

    // Kernel is only writable while idle so a frame always sees one consistent kernel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NTAP; k++) wt_q[k] <= '0;
        end else if ((state_q == IDLE) && bus_io.wt_wr && (bus_io.wt_idx < 5'(NTAP))) begin
            wt_q[bus_io.wt_idx] <= bus_io.wt_data;
        end
    end

    conv_window_gen #(
        .LineW (IMG_W)
    ) u_window (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (frame_start),
        .pix_vld_i (rd_vld_q),
        .pix_i     (bus_io.sram_rdata),
        .win_o     (win),
        .win_vld_o (win_vld),
        .row_o     (win_row),
        .col_o     (win_col)
    );

    // Pixels are unsigned: zero-extend to 9-bit signed before the signed multiply.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_vld_q <= 1'b0;
            for (int k = 0; k < NTAP; k++) prod_q[k] <= '0;
        end else begin
            prod_vld_q <= win_vld;
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K; j++) begin
                    prod_q[i*K+j] <= prod_t'($signed({1'b0, win[i][j]})) * prod_t'(wt_q[i*K+j]);
                end
            end
        end
    end

    always_comb begin
        sum = '0;
        for (int k = 0; k < NTAP; k++) sum = sum + acc_t'(prod_q[k]);
    end

    always_comb begin
        sum_sh = sum >>> SHIFT;
        if (sum < 0) begin
            pix_res = '0;
        end else if (sum_sh > acc_t'(255)) begin
            pix_res = 8'hFF;
        end else begin
            pix_res = sum_sh[7:0];
        end
    end

    // out_cnt_q is the address of the next output; out_addr_q holds the last emitted one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conv_out_q <= '0;
            out_addr_q <= '0;
            out_cnt_q  <= '0;
            out_vld_q  <= 1'b0;
        end else begin
            out_vld_q <= prod_vld_q;
            if (frame_start) begin
                out_cnt_q <= '0;
            end else if (prod_vld_q) begin
                conv_out_q <= pix_res;
                out_addr_q <= out_cnt_q;
                out_cnt_q  <= out_cnt_q + 10'd1;
            end
        end
    end

    assign bus_io.sram_re    = (state_q == READ);
    assign bus_io.sram_raddr = raddr_q;
    assign bus_io.conv_out   = conv_out_q;
    assign bus_io.out_addr   = out_addr_q;
    assign bus_io.out_vld    = out_vld_q;
    assign bus_io.busy       = (state_q != IDLE);
    assign bus_io.done       = (state_q == DONE);

    win_pos_a: assert property (@(posedge clk) disable iff (!rst_n)
        win_vld |-> (win_row >= CW'(K - 1)) && (win_col >= CW'(K - 1)));

    out_count_a: assert property (@(posedge clk) disable iff (!rst_n)
        prod_vld_q |-> (out_cnt_q < 10'(OUT_W * OUT_W)));

endmodule
